// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the UART receive framing sequencer
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    HOLD
  } frm_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CSUM    = 3'd2,
    ERR_FRAMING = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_OVERRUN = 3'd5
  } frm_err_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload register array, one sync write port, one async read port
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - assembles SYNC/LEN/payload/CSUM frames from uart_rx byte strobes
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_HZ        = 200_000_000,
  parameter int         BAUD          = 9600,
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT,
  parameter int         TIMEOUT_BYTES = 4,
  localparam int        LW            = $clog2(MAX_LEN + 1),
  localparam int        AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rx_err,
  output logic          frm_valid,
  input  logic          frm_ready,
  output logic [LW-1:0] frm_len,
  input  logic [AW-1:0] frm_rd_addr,
  output logic [7:0]    frm_rd_data,
  output logic [15:0]   frm_cnt,
  output logic          err_stb,
  output logic [2:0]    err_code
);

  localparam int TO_CYC = CLK_HZ / BAUD * 10 * TIMEOUT_BYTES;
  localparam int TW     = $clog2(TO_CYC + 1);

  frm_state_t    state, state_d;
  logic [LW-1:0] len, len_d, idx, idx_d, frm_len_d;
  logic [7:0]    sum, sum_d;
  logic [TW-1:0] to_cnt, to_d;
  logic [15:0]   cnt_d;
  frm_err_t      err_d;
  logic          we, byte_ev, active;

  assign byte_ev   = rx_done & ~rx_err;
  assign active    = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign frm_valid = (state == HOLD);

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (AW'(idx)),
    .wdata (rx_data),
    .raddr (frm_rd_addr),
    .rdata (frm_rd_data)
  );

  always_comb begin
    state_d   = state;
    len_d     = len;
    idx_d     = idx;
    sum_d     = sum;
    frm_len_d = frm_len;
    cnt_d     = frm_cnt;
    err_d     = ERR_NONE;
    we        = 1'b0;
    to_d      = (active && !byte_ev) ? to_cnt + TW'(1) : '0;

    // Framing beats timeout; timeout only fires on a cycle with no byte.
    if (active && rx_err) begin
      err_d   = ERR_FRAMING;
      state_d = IDLE;
    end else if (active && !byte_ev && to_cnt == TW'(TO_CYC - 1)) begin
      err_d   = ERR_TIMEOUT;
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (byte_ev && rx_data == SYNC_BYTE) state_d = LEN;
        end
        LEN: begin
          if (byte_ev) begin
            if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
              err_d   = ERR_LEN;
              state_d = IDLE;
            end else begin
              len_d   = LW'(rx_data);
              sum_d   = rx_data;
              idx_d   = '0;
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (byte_ev) begin
            we    = 1'b1;
            sum_d = sum + rx_data;
            idx_d = idx + LW'(1);
            if (idx == len - LW'(1)) state_d = CSUM;
          end
        end
        CSUM: begin
          if (byte_ev) begin
            if (rx_data == sum) begin
              frm_len_d = len;
              cnt_d     = frm_cnt + 16'd1;
              state_d   = HOLD;
            end else begin
              err_d   = ERR_CSUM;
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
          if (byte_ev) err_d = ERR_OVERRUN;
          if (frm_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      len      <= '0;
      idx      <= '0;
      sum      <= '0;
      to_cnt   <= '0;
      frm_len  <= '0;
      frm_cnt  <= '0;
      err_stb  <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state    <= state_d;
      len      <= len_d;
      idx      <= idx_d;
      sum      <= sum_d;
      to_cnt   <= to_d;
      frm_len  <= frm_len_d;
      frm_cnt  <= cnt_d;
      err_stb  <= (err_d != ERR_NONE);
      err_code <= err_d;
    end
  end

endmodule
